// File: rtl/ram_pipe.sv
// Byte-lane RAM with a self-clearing init sequence and a fixed-latency read pipeline.
// Out-of-range accesses are flagged rather than aliased.
module ram_pipe #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LANE_WIDTH  = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned RD_LATENCY  = 2,
  parameter bit          WRITE_FIRST = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                we,
  input  logic [ADDR_WIDTH-1:0]               wr_addr,
  input  logic [DATA_WIDTH-1:0]               wr_din,
  input  logic [(DATA_WIDTH/LANE_WIDTH)-1:0]  wr_be,
  input  logic                                re,
  input  logic [ADDR_WIDTH-1:0]               rd_addr,
  output logic [DATA_WIDTH-1:0]               rd_dout,
  output logic                                rd_valid,
  output logic                                rd_err,
  output logic                                wr_err,
  output logic                                busy
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / LANE_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    busy_q, busy_d;
  logic                    wr_err_q, wr_err_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [NUM_LANES-1:0]    lane_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  logic                    wr_acc, rd_acc, wr_in, rd_in;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic [RD_LATENCY-1:0]   vld_q, vld_d, err_q, err_d, in_v, in_e;
  logic [DATA_WIDTH-1:0]   dat_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0]   dat_d [RD_LATENCY];
  logic [DATA_WIDTH-1:0]   in_d  [RD_LATENCY];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: walk the clear pointer through every word once
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
      if (ptr_q == LAST_PTR) begin
        state_d = ST_READY;
        ptr_d   = '0;
      end
    end
  end

  // Outputs: busy, request acceptance and the single memory write port
  always_comb begin
    busy_d    = (state_d == ST_INIT);
    wr_acc    = (state_q == ST_READY) && !rst && we;
    rd_acc    = (state_q == ST_READY) && !rst && re;
    wr_in     = {1'b0, wr_addr} < DEPTH_X;
    rd_in     = {1'b0, rd_addr} < DEPTH_X;
    wr_err_d  = wr_acc && !wr_in;
    lane_we   = '0;
    mem_waddr = wr_addr;
    mem_wdata = wr_din;
    if (state_q == ST_INIT) begin
      lane_we   = '1;
      mem_waddr = ptr_q;
      mem_wdata = '0;
    end else if (wr_acc && wr_in) begin
      lane_we   = wr_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      if (lane_we[l]) mem[mem_waddr][l*LANE_WIDTH +: LANE_WIDTH] <= mem_wdata[l*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  // Read word at the request edge, optionally forwarding same-address write lanes
  always_comb begin
    rd_word = rd_in ? mem[rd_addr] : '0;
    if (WRITE_FIRST && wr_acc && wr_in && rd_in && (wr_addr == rd_addr)) begin
      for (int l = 0; l < int'(NUM_LANES); l++) begin
        if (wr_be[l]) rd_word[l*LANE_WIDTH +: LANE_WIDTH] = wr_din[l*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Read pipeline; the last stage holds its data between valid pulses
  always_comb begin
    in_v    = '0;
    in_e    = '0;
    in_v[0] = rd_acc;
    in_e[0] = !rd_in;
    in_d[0] = rd_word;
    for (int s = 1; s < int'(RD_LATENCY); s++) begin
      in_v[s] = vld_q[s-1];
      in_e[s] = err_q[s-1];
      in_d[s] = dat_q[s-1];
    end
    vld_d = in_v;
    err_d = in_v & in_e;
    for (int s = 0; s < int'(RD_LATENCY); s++) dat_d[s] = in_d[s];
    if (!in_v[RD_LATENCY-1]) dat_d[RD_LATENCY-1] = dat_q[RD_LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      err_q    <= '0;
      wr_err_q <= 1'b0;
      busy_q   <= 1'b1;
      for (int s = 0; s < int'(RD_LATENCY); s++) dat_q[s] <= '0;
    end else begin
      vld_q    <= vld_d;
      err_q    <= err_d;
      wr_err_q <= wr_err_d;
      busy_q   <= busy_d;
      for (int s = 0; s < int'(RD_LATENCY); s++) dat_q[s] <= dat_d[s];
    end
  end

  assign rd_dout  = dat_q[RD_LATENCY-1];
  assign rd_valid = vld_q[RD_LATENCY-1];
  assign rd_err   = err_q[RD_LATENCY-1];
  assign wr_err   = wr_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ram_pipe.sv
// Directed bench for ram_pipe: default build, a read-old-data build and a DEPTH=12 build
// share one stimulus stream.
module tb_ram_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, re = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr = '0, wr_be = '0;
  logic [31:0] wr_din = '0;

  logic [31:0] rd_dout_m, rd_dout_w, rd_dout_d;
  logic        rd_valid_m, rd_err_m, wr_err_m, busy_m;
  logic        rd_valid_w, rd_err_w, wr_err_w, busy_w;
  logic        rd_valid_d, rd_err_d, wr_err_d, busy_d;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ram_pipe u_main (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be),
    .re(re), .rd_addr(rd_addr), .rd_dout(rd_dout_m), .rd_valid(rd_valid_m),
    .rd_err(rd_err_m), .wr_err(wr_err_m), .busy(busy_m)
  );

  ram_pipe #(.WRITE_FIRST(1'b0)) u_wf0 (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be),
    .re(re), .rd_addr(rd_addr), .rd_dout(rd_dout_w), .rd_valid(rd_valid_w),
    .rd_err(rd_err_w), .wr_err(wr_err_w), .busy(busy_w)
  );

  ram_pipe #(.DEPTH(12)) u_d12 (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be),
    .re(re), .rd_addr(rd_addr), .rd_dout(rd_dout_d), .rd_valid(rd_valid_d),
    .rd_err(rd_err_d), .wr_err(wr_err_d), .busy(busy_d)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [3:0]  ra;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic w, logic [3:0] wa, logic [31:0] wd, logic [3:0] be,
                              logic r, logic [3:0] ra, logic ev, logic [31:0] ed);
    vec_t v;
    v.we = w; v.wa = wa; v.wd = wd; v.be = be;
    v.re = r; v.ra = ra; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(logic w, logic [3:0] wa, logic [31:0] wd, logic [3:0] be,
                       logic r, logic [3:0] ra);
    we = w; wr_addr = wa; wr_din = wd; wr_be = be; re = r; rd_addr = ra;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles of the default build and notes any output activity meanwhile
  task automatic count_busy(output int n, output int activity);
    n = 0;
    activity = 0;
    while (busy_m && n < 40) begin
      n++;
      step();
      if (rd_valid_m || wr_err_m || rd_err_m) activity++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, act;

    // Reset and first init, with requests asserted that must be ignored
    rst = 1'b1;
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);
    step();
    step();
    chk("rst.busy", busy_m, 1);
    chk("rst.valid", rd_valid_m, 0);
    chk("rst.dout", rd_dout_m, 0);
    chk("rst.rd_err", rd_err_m, 0);
    chk("rst.wr_err", wr_err_m, 0);
    rst = 1'b0;
    drive(1'b1, 4'd5, 32'hFFFF_FFFF, 4'hF, 1'b1, 4'd5);
    count_busy(n, act);
    chk("init.busy_cycles", n, 16);
    chk("init.ignored_req", act, 0);
    chk("init.d12_busy_low", busy_d, 0);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0);

    // Directed vectors: inputs for one edge, expected outputs right after it
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 1, 5, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 0, 0, 1, 32'h0));
    tbl.push_back(mk(1, 3, 32'hDEADBEEF,  4'hF, 0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 3, 32'h000000AA,  4'h1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 1, 3, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 0, 0, 1, 32'hDEADBEAA));
    tbl.push_back(mk(1, 7, 32'h12345678,  4'hF, 1, 7, 0, 32'hDEADBEAA));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 0, 0, 1, 32'h12345678));
    tbl.push_back(mk(1, 0, 32'h10,        4'hF, 0, 0, 0, 32'h12345678));
    tbl.push_back(mk(1, 1, 32'h11,        4'hF, 0, 0, 0, 32'h12345678));
    tbl.push_back(mk(1, 2, 32'h12,        4'hF, 0, 0, 0, 32'h12345678));
    tbl.push_back(mk(1, 3, 32'h13,        4'hF, 0, 0, 0, 32'h12345678));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 1, 0, 0, 32'h12345678));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 1, 1, 1, 32'h10));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 1, 2, 1, 32'h11));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 1, 3, 1, 32'h12));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 0, 0, 1, 32'h13));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 0, 0, 0, 32'h13));
    tbl.push_back(mk(1, 5, 32'hAABBCCDD,  4'h6, 1, 5, 0, 32'h13));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 0, 0, 1, 32'h00BBCC00));
    tbl.push_back(mk(1, 5, 32'hFFFFFFFF,  4'h0, 0, 0, 0, 32'h00BBCC00));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 1, 5, 0, 32'h00BBCC00));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 0, 0, 1, 32'h00BBCC00));
    tbl.push_back(mk(1, 6, 32'h11111111,  4'hF, 1, 7, 0, 32'h00BBCC00));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 0, 0, 1, 32'h12345678));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 1, 6, 0, 32'h12345678));
    tbl.push_back(mk(1, 6, 32'h22222222,  4'hF, 0, 0, 1, 32'h11111111));
    tbl.push_back(mk(0, 0, 32'h0,         4'h0, 0, 0, 0, 32'h11111111));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].ra);
      step();
      chk($sformatf("vec%0d.valid", i), rd_valid_m, tbl[i].ev);
      chk($sformatf("vec%0d.dout", i), rd_dout_m, tbl[i].ed);
      chk($sformatf("vec%0d.errs", i), {rd_err_m, wr_err_m}, 0);
      if (i == 7 || i == 19) begin
        chk($sformatf("vec%0d.wf0_valid", i), rd_valid_w, 1);
        chk($sformatf("vec%0d.wf0_dout", i), rd_dout_w, 0);
      end
    end

    // Out-of-range accesses on the DEPTH=12 build
    drive(1, 4'd14, 32'hCAFEF00D, 4'hF, 0, 0);
    step();
    chk("d12.wr_err_pulse", wr_err_d, 1);
    chk("main.wr_err_inrange", wr_err_m, 0);
    drive(0, 0, 32'h0, 4'h0, 1, 4'd13);
    step();
    chk("d12.wr_err_clear", wr_err_d, 0);
    drive(0, 0, 32'h0, 4'h0, 1, 4'd0);
    step();
    chk("d12.oor_valid", rd_valid_d, 1);
    chk("d12.oor_err", rd_err_d, 1);
    chk("d12.oor_dout", rd_dout_d, 0);
    drive(0, 0, 32'h0, 4'h0, 0, 0);
    step();
    chk("d12.addr0_valid", rd_valid_d, 1);
    chk("d12.addr0_err", rd_err_d, 0);
    chk("d12.addr0_dout", rd_dout_d, 32'h10);

    // Reset mid-init restarts the full clear
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (8) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midinit.busy", busy_m, 1);
    count_busy(n, act);
    chk("midinit.busy_cycles", n, 16);

    // Reset one cycle after a read request discards it
    drive(0, 0, 32'h0, 4'h0, 1, 4'd3);
    step();
    drive(0, 0, 32'h0, 4'h0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort.valid", rd_valid_m, 0);
    chk("abort.dout", rd_dout_m, 0);
    count_busy(n, act);
    chk("abort.busy_cycles", n, 16);
    chk("abort.no_stray_valid", act, 0);

    // Cleared memory reads back zero with latency 2
    drive(0, 0, 32'h0, 4'h0, 1, 4'd3);
    step();
    drive(0, 0, 32'h0, 4'h0, 0, 0);
    chk("clear.lat1_valid", rd_valid_m, 0);
    step();
    chk("clear.lat2_valid", rd_valid_m, 1);
    chk("clear.dout", rd_dout_m, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_pipe.md
RAM_PIPE -- requirements
Module: ram_pipe

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: width of the write and read addresses.
REQ-002 Parameter DATA_WIDTH, default 32: word width.
REQ-003 Parameter LANE_WIDTH, default 8: byte-enable granularity; DATA_WIDTH SHALL be a multiple of LANE_WIDTH; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
REQ-004 Parameter DEPTH, default 16: number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
REQ-005 Parameter RD_LATENCY, default 2, legal 1..4: clock edges from read request to rd_valid.
REQ-006 Parameter WRITE_FIRST, default 1: read-during-write to the same address; 1 returns the new data, 0 returns the old data.
REQ-007 clk  input  1  sole clock; all state updates on the rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 we  input  1  write request, sampled when busy=0.
REQ-010 wr_addr  input  ADDR_WIDTH  write address.
REQ-011 wr_din  input  DATA_WIDTH  write data.
REQ-012 wr_be  input  NUM_LANES  lane write enables; bit i covers lane i (LSB lane = bit 0).
REQ-013 re  input  1  read request, sampled when busy=0.
REQ-014 rd_addr  input  ADDR_WIDTH  read address.
REQ-015 rd_dout  output  DATA_WIDTH  read data; holds its last value when rd_valid=0.
REQ-016 rd_valid  output  1  one-cycle pulse per accepted read.
REQ-017 rd_err  output  1  qualifies rd_dout; high with rd_valid when the read address was >= DEPTH.
REQ-018 wr_err  output  1  one-cycle pulse the cycle after an accepted write with wr_addr >= DEPTH.
REQ-019 busy  output  1  high while the init-clear sequence runs.

Function
REQ-020 Controller FSM states INIT and READY; rst forces INIT with clear pointer = 0.
REQ-021 In INIT, each cycle writes zero to mem[ptr] and increments ptr; on ptr = DEPTH-1 the next state is READY; busy=1 throughout INIT, so busy is high for exactly DEPTH cycles after rst falls.
REQ-022 In INIT, we and re are ignored: no memory update, no rd_valid, no rd_err, no wr_err.
REQ-023 In READY, an accepted write (we=1) updates only the lanes with wr_be[i]=1 at the rising edge; wr_be = 0 leaves memory unchanged and raises no error.
REQ-024 A write with wr_addr >= DEPTH leaves memory unchanged and pulses wr_err on the next cycle.
REQ-025 In READY, an accepted read (re=1) sampled at edge N produces rd_valid=1 with rd_dout during the cycle after edge N+RD_LATENCY-1, i.e. RD_LATENCY edges after the request.
REQ-026 The read pipeline is fully pipelined: back-to-back reads on every cycle produce back-to-back rd_valid pulses, in order, with no bubbles.
REQ-027 A read with rd_addr >= DEPTH returns rd_dout = 0 with rd_valid=1 and rd_err=1.
REQ-028 Same-cycle we and re to the same in-range address with WRITE_FIRST=1 returns old data merged with wr_din on the enabled lanes; with WRITE_FIRST=0 it returns the old word.
REQ-029 Simultaneous reads and writes to different addresses SHALL not interact.
REQ-030 Read data reflects memory contents at the request edge; writes after the request do not alter in-flight reads.

Reset
REQ-031 While rst=1: rd_dout=0, rd_valid=0, rd_err=0, wr_err=0, busy=1, and all in-flight reads are discarded.
REQ-032 rst asserted mid-INIT or mid-read restarts INIT from ptr=0; no rd_valid from a pre-reset request ever appears.
REQ-033 After INIT completes, every location in 0..DEPTH-1 reads as 0.

Verification
REQ-034 Reset 1 cycle, release -> busy high exactly 16 cycles, then low; read addr 5 -> rd_dout=0x00000000, rd_valid exactly 2 edges after the request.
REQ-035 Write addr 3 = 0xDEADBEEF with wr_be=4'b1111, then write addr 3 = 0x000000AA with wr_be=4'b0001, then read addr 3 -> 0xDEADBEAA.
REQ-036 Same cycle: we to addr 7 = 0x12345678 with wr_be=4'b1111, and re from addr 7 (old value 0x0) -> WRITE_FIRST=1 returns 0x12345678; WRITE_FIRST=0 returns 0x00000000.
REQ-037 Reads of addrs 0,1,2,3 on consecutive cycles after writing 0x10,0x11,0x12,0x13 -> four consecutive rd_valid pulses with data 0x10..0x13 in order.
REQ-038 Build with DEPTH=12: write addr 14 -> wr_err pulse, memory unchanged; read addr 13 -> rd_valid=1, rd_err=1, rd_dout=0.
REQ-039 Assert rst at INIT cycle 8 and at one cycle after a read request -> busy lasts 16 cycles from the second release, and no rd_valid appears for the aborted read.
